// File: rtl/res_pkg.sv
// Shared widths, element types and arithmetic helpers for the residual shortcut path.
package res_pkg;

  localparam int DATA_W = 16;
  localparam int SUM_W  = 18;

  typedef logic signed [DATA_W-1:0] data_t;
  typedef data_t [3:0]              patch_t;

  // Floor average of four signed samples; the 18-bit sum cannot overflow.
  function automatic data_t avg4(input data_t a, input data_t b,
                                 input data_t c, input data_t d);
    logic signed [SUM_W-1:0] s;
    s = {{(SUM_W-DATA_W){a[DATA_W-1]}}, a} + {{(SUM_W-DATA_W){b[DATA_W-1]}}, b}
      + {{(SUM_W-DATA_W){c[DATA_W-1]}}, c} + {{(SUM_W-DATA_W){d[DATA_W-1]}}, d};
    s = s >>> 2;
    return s[DATA_W-1:0];
  endfunction

  function automatic data_t sat_add16(input data_t a, input data_t b);
    logic signed [DATA_W:0] r;
    r = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (r[DATA_W] != r[DATA_W-1])
      return r[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    return r[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/res_fifo.sv
// Synchronous FIFO with flush; the caller only issues legal push/pop combinations.
module res_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  // NOTE: storage has no reset; only the pointers define what is valid, so
  // clearing the array would buy nothing but a large reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign level = count;

endmodule

// File: rtl/residual_shortcut.sv
// Pools the 2x2 shortcut patch per channel, queues it, and adds it with
// saturation to the matching main-path convolution result.
module residual_shortcut
  import res_pkg::*;
#(
  parameter int FM_DEPTH = 64,
  parameter int Q_DEPTH  = 4
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                verticle_sync,
  input  logic                                mode_in,
  input  logic                                c_valid,
  input  logic [FM_DEPTH-1:0][3:0][DATA_W-1:0] C,
  input  logic                                conv_valid,
  input  logic [FM_DEPTH-1:0][DATA_W-1:0]      conv_data,
  output logic                                data_out_valid,
  output logic [FM_DEPTH-1:0][DATA_W-1:0]      data_out,
  output logic [$clog2(Q_DEPTH):0]             q_level,
  output logic                                err_overflow,
  output logic                                err_underflow
);

  localparam int VEC_W = FM_DEPTH * DATA_W;

  logic                              flush;
  logic                              push;
  logic                              pop;
  logic                              fifo_full;
  logic                              fifo_empty;
  logic [FM_DEPTH-1:0][DATA_W-1:0]   avg_vec;
  logic [FM_DEPTH-1:0][DATA_W-1:0]   head_vec;
  logic [FM_DEPTH-1:0][DATA_W-1:0]   shortcut;
  logic [FM_DEPTH-1:0][DATA_W-1:0]   sum_vec;
  patch_t                            patch;

  assign flush = verticle_sync | ~mode_in;
  assign pop   = conv_valid & ~flush & ~fifo_empty;
  // An empty-FIFO pop consumes this cycle's average directly, so nothing is written.
  assign push  = c_valid & ~flush & ~(conv_valid & fifo_empty) & (~fifo_full | conv_valid);

  res_fifo #(
    .WIDTH (VEC_W),
    .DEPTH (Q_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (avg_vec),
    .rdata (head_vec),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (q_level)
  );

  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    avg_vec = '0;
    patch   = '0;
    for (int i = 0; i < FM_DEPTH; i++) begin
      patch      = C[i];
      avg_vec[i] = avg4(patch[0], patch[1], patch[2], patch[3]);
    end
  end

  always_comb begin
    shortcut = '0;
    if (!fifo_empty)  shortcut = head_vec;
    else if (c_valid) shortcut = avg_vec;
  end

  always_comb begin
    sum_vec = '0;
    for (int i = 0; i < FM_DEPTH; i++)
      sum_vec[i] = sat_add16(conv_data[i], shortcut[i]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_out_valid <= 1'b0;
      data_out       <= '0;
      err_overflow   <= 1'b0;
      err_underflow  <= 1'b0;
    end else if (flush) begin
      data_out_valid <= 1'b0;
      data_out       <= '0;
      if (verticle_sync) begin
        err_overflow  <= 1'b0;
        err_underflow <= 1'b0;
      end
    end else begin
      data_out_valid <= conv_valid;
      if (conv_valid) data_out <= sum_vec;
      if (c_valid && fifo_full && !conv_valid)   err_overflow  <= 1'b1;
      if (conv_valid && fifo_empty && !c_valid)  err_underflow <= 1'b1;
    end
  end

endmodule

// File: doc/residual_shortcut.md
Name: residual_shortcut

Overview:
- Downstream companion of the 3x3 window generator, fed by its C outputs: per input channel, the 2x2 patch (window positions 1, 2, 4, 5) accompanied by the window-valid strobe.
- Per channel, computes the 2x2 average-pool of that patch and queues the result in a small FIFO.
- When the main-path convolution result for the same output pixel arrives, pops the queued value, adds it to the result with signed saturation, and emits the residual sum.
- Absorbs the latency difference between the shortcut path and the convolution path within one frame.

Parameters:
- FM_DEPTH, 64, number of channels (shortcut channels = main-path output channels)
- Q_DEPTH, 4, FIFO entries of pooled vectors; power of two, >=2

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- verticle_sync  input  1  frame start; synchronous flush
- mode_in  input  1  0 = parameter load (block idle/flushed), 1 = calculate
- c_valid  input  1  driven by window generator data_out_valid; C is valid this cycle
- C  input  [15:0] x [FM_DEPTH-1:0][3:0]  2x2 shortcut patch per channel, signed
- conv_valid  input  1  main-path result valid this cycle
- conv_data  input  [15:0] x [FM_DEPTH-1:0]  main-path result, signed
- data_out_valid  output  1  residual sum valid
- data_out  output  [15:0] x [FM_DEPTH-1:0]  residual sum, signed
- q_level  output  $clog2(Q_DEPTH)+1  FIFO occupancy
- err_overflow  output  1  sticky: push dropped because FIFO full
- err_underflow  output  1  sticky: conv_valid with no shortcut available

Behaviour:
- Reset (rstn=0, async): every output zero; FIFO empty; pointers zero.
- Flush (verticle_sync=1 or mode_in=0, synchronous, highest priority over every other event):
  - FIFO emptied, data_out_valid=0, data_out=0.
  - c_valid and conv_valid are ignored that cycle.
  - err flags cleared on verticle_sync only; they hold through mode_in=0.
- Pool, combinational per channel:
  - sum = sign-extended C[i][0]+C[i][1]+C[i][2]+C[i][3] in 18 bits.
  - avg = sum >>> 2 (arithmetic shift, floor), truncated to 16 bits; the result always fits.
- Push: on c_valid with FIFO not full, write the avg vector at the clock edge.
- Push when full: if conv_valid in the same cycle, the pop frees a slot and the push proceeds. Otherwise the vector is dropped, err_overflow set, and the FIFO is unchanged.
- Pop: on conv_valid with FIFO non-empty, read the head entry.
- Pop when empty, c_valid also 1 (bypass): use the avg being computed this cycle; nothing is written; q_level stays 0.
- Pop when empty, c_valid 0: shortcut value = 0, err_underflow set; an output is still produced.
- Add: r = sign-extended conv_data[i] + shortcut[i] in 17 bits, saturated to [-32768, 32767].
- Output timing:
  - data_out registered; data_out_valid=1 exactly one cycle after conv_valid (latency 1).
  - data_out holds its value when valid=0.
- FIFO pointers wrap modulo Q_DEPTH; q_level changes +1 on push only, -1 on pop only, 0 on both.
- No backpressure. The producer guarantees c_valid at most once per 8 cycles; conv_valid may arrive at any rate.

Decomposition:
- Package res_pkg:
  - DATA_W=16, SUM_W=18
  - typedef of the channel vector
  - functions avg4(a,b,c,d) and sat_add16(a,b)
- One sub-module: res_fifo. Synchronous FIFO with parameters WIDTH and DEPTH; provides flush, push, pop, full, empty, level, head data. Bypass logic and error flags stay in residual_shortcut.

Test Plan:
- All channels C={4,8,12,16}, c_valid pulse; 5 cycles later conv_valid with conv_data=100 -> one cycle later data_out_valid=1, data_out=110 on every channel, q_level back to 0.
- Rounding and saturation:
  - C={-1,-1,-1,-2} (avg=-2) with conv_data=-3 -> data_out=-5.
  - C={32767 x4} (avg=32767) with conv_data=1 -> data_out=32767.
  - C={-32768 x4} with conv_data=-1 -> data_out=-32768.
- Overflow:
  - Push 5 vectors (values 1..5) with Q_DEPTH=4 and no pops -> 5th dropped, err_overflow=1, q_level=4.
  - Pop 4 times -> shortcut values 1,2,3,4 in order.
  - Repeat with the 5th c_valid coincident with a conv_valid -> no drop, err_overflow=0.
- Empty FIFO with simultaneous c_valid and conv_valid (C avg=7, conv_data=3) -> data_out=10, q_level=0, no error flags.
- conv_valid alone on empty FIFO (conv_data=9) -> data_out=9, err_underflow=1.
  - Next verticle_sync -> err_underflow=0, q_level=0.
- Reset and flush mid-operation:
  - q_level=3, assert rstn=0 between clock edges -> all outputs 0 immediately.
  - After release, q_level=3 again then mode_in=0 for one cycle -> q_level=0, a coincident conv_valid produces no output, sticky flags retained.
